fetch_queue: RTL and testbench

Instruction queue between the first fetch stage and decode. It accepts 64-bit fetch packets carrying two instruction slots, each with its own per-slot valid and branch-prediction bit. It compacts the valid slots into a circular buffer and hands one instruction per cycle to decode over a valid/ready handshake. It drives `queue_full` back to fetch, flushes on branch mispredict, and discards an imem response that was already in flight when the flush occurred.

---
 rtl/fetch_queue.sv | 139 +++++++++++++
 tb/tb_fetch_queue.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue.sv
// fetch_queue
//   Instruction queue sitting between the first fetch stage and decode.
//   A fetch packet carries two 32-bit instruction slots. The valid slots are
//   compacted into a circular buffer, and decode drains one instruction per
//   cycle over a valid/ready handshake. A branch mispredict flushes the queue.
//   When the mispredict lands while an imem request is still outstanding, the
//   next response to come back is stale and gets discarded.
//
// Ports
//   clk, rst            clock; synchronous active-high reset
//   imem_resp           fetch packet valid this cycle
//   imem_rdata[63:0]    instruction pair; [31:0] slot 0, [63:32] slot 1
//   fetch_pc[31:0]      packet PC, 8-byte aligned
//   fetch_valid[1:0]    per-slot valid
//   fetch_pred[1:0]     per-slot predicted-taken
//   imem_stall          fetch has an outstanding imem request
//   branch_mispredict   flush request
//   queue_full          fewer than two free slots
//   dec_valid           head entry available
//   dec_ready           decode accepts the head entry
//   dec_inst/pc/pred    head entry contents
//   overflow_err        sticky; a packet arrived while the queue was full
module fetch_queue #(
    parameter int DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        imem_resp,
    input  logic [63:0] imem_rdata,
    input  logic [31:0] fetch_pc,
    input  logic [1:0]  fetch_valid,
    input  logic [1:0]  fetch_pred,
    input  logic        imem_stall,
    input  logic        branch_mispredict,
    output logic        queue_full,
    output logic        dec_valid,
    input  logic        dec_ready,
    output logic [31:0] dec_inst,
    output logic [31:0] dec_pc,
    output logic        dec_pred,
    output logic        overflow_err
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FULL_THRESH = (PTR_W + 1)'(DEPTH - 1);

    // Number of valid slots in a packet (0..2).
    function automatic logic [1:0] slot_count(input logic [1:0] v);
        return {1'b0, v[1]} + {1'b0, v[0]};
    endfunction

    // Entry storage: data only, never reset.
    logic [31:0]      inst_mem [DEPTH];
    logic [31:0]      pc_mem   [DEPTH];
    logic             pred_mem [DEPTH];

    // Control state.
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [PTR_W:0]   count;
    logic             drop_pending;
    logic             overflow_q;

    logic             enq;
    logic             deq;
    logic             ovf_hit;
    logic             drop_hit;
    logic [1:0]       n_in;
    logic [PTR_W-1:0] slot1_idx;

    assign queue_full = (count >= FULL_THRESH);
    assign dec_valid  = (count != '0);

    // A pending drop and a same-cycle flush both take precedence over the
    // packet, so neither an enqueue nor an overflow can be recorded then.
    assign enq      = imem_resp && !queue_full && !drop_pending && !branch_mispredict;
    assign ovf_hit  = imem_resp &&  queue_full && !drop_pending && !branch_mispredict;
    assign drop_hit = imem_resp && drop_pending;
    assign deq      = dec_valid && dec_ready && !branch_mispredict;

    assign n_in = enq ? slot_count(fetch_valid) : 2'd0;

    // Slot 1 lands right after slot 0 when slot 0 is present, otherwise at
    // tail itself, which keeps the buffer compact.
    assign slot1_idx = tail + PTR_W'(fetch_valid[0]);

    assign dec_inst = inst_mem[head];
    assign dec_pc   = pc_mem[head];
    assign dec_pred = pred_mem[head];
    assign overflow_err = overflow_q;

    // ---- write stage: packet slots into storage ----
    always_ff @(posedge clk) begin
        if (enq && fetch_valid[0]) begin
            inst_mem[tail] <= imem_rdata[31:0];
            pc_mem[tail]   <= fetch_pc;
            pred_mem[tail] <= fetch_pred[0];
        end
        if (enq && fetch_valid[1]) begin
            inst_mem[slot1_idx] <= imem_rdata[63:32];
            pc_mem[slot1_idx]   <= fetch_pc + 32'd4;
            pred_mem[slot1_idx] <= fetch_pred[1];
        end
    end

    // ---- control stage: pointers, occupancy, drop and overflow flags ----
    always_ff @(posedge clk) begin
        if (rst) begin
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            drop_pending <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            if (branch_mispredict) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                tail  <= tail + PTR_W'(n_in);
                head  <= head + PTR_W'(deq);
                count <= count + (PTR_W + 1)'(n_in) - (PTR_W + 1)'(deq);
            end

            // A new mispredict with a request still in flight re-arms the
            // drop even if a stale response is being discarded this cycle.
            if (branch_mispredict && imem_stall) begin
                drop_pending <= 1'b1;
            end else if (drop_hit) begin
                drop_pending <= 1'b0;
            end

            if (ovf_hit) begin
                overflow_q <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_resp;
    logic [63:0] imem_rdata;
    logic [31:0] fetch_pc;
    logic [1:0]  fetch_valid;
    logic [1:0]  fetch_pred;
    logic        imem_stall;
    logic        branch_mispredict;
    logic        queue_full;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_inst;
    logic [31:0] dec_pc;
    logic        dec_pred;
    logic        overflow_err;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk               (clk),
        .rst               (rst),
        .imem_resp         (imem_resp),
        .imem_rdata        (imem_rdata),
        .fetch_pc          (fetch_pc),
        .fetch_valid       (fetch_valid),
        .fetch_pred        (fetch_pred),
        .imem_stall        (imem_stall),
        .branch_mispredict (branch_mispredict),
        .queue_full        (queue_full),
        .dec_valid         (dec_valid),
        .dec_ready         (dec_ready),
        .dec_inst          (dec_inst),
        .dec_pc            (dec_pc),
        .dec_pred          (dec_pred),
        .overflow_err      (overflow_err)
    );

    // Reference model: a plain FIFO of entries plus two flags.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        pred;
    } entry_t;

    entry_t      mq[$];
    bit          m_drop;
    bit          m_ovf;
    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] pc_next;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic bit m_full();
        return (DEPTH - mq.size()) < 2;
    endfunction

    // Apply one clock edge of the rules to the model using the current inputs.
    task automatic model_edge();
        bit full;
        full = m_full();
        if (rst) begin
            mq.delete();
            m_drop = 1'b0;
            m_ovf  = 1'b0;
            return;
        end
        if (branch_mispredict) begin
            mq.delete();
        end else begin
            if (dec_ready && mq.size() != 0) void'(mq.pop_front());
            if (imem_resp && !m_drop) begin
                if (full) begin
                    m_ovf = 1'b1;
                end else begin
                    if (fetch_valid[0]) mq.push_back('{imem_rdata[31:0], fetch_pc, fetch_pred[0]});
                    if (fetch_valid[1]) mq.push_back('{imem_rdata[63:32], fetch_pc + 32'd4, fetch_pred[1]});
                end
            end
        end
        if (branch_mispredict && imem_stall) m_drop = 1'b1;
        else if (imem_resp && m_drop)        m_drop = 1'b0;
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        chk("dec_valid", dec_valid, mq.size() != 0);
        chk("queue_full", queue_full, m_full());
        chk("overflow_err", overflow_err, m_ovf);
        if (mq.size() != 0) begin
            chk("dec_inst", dec_inst, mq[0].inst);
            chk("dec_pc", dec_pc, mq[0].pc);
            chk("dec_pred", dec_pred, mq[0].pred);
        end
    endtask

    task automatic idle();
        rst = 1'b0; imem_resp = 1'b0; branch_mispredict = 1'b0;
        imem_stall = 1'b0; dec_ready = 1'b0;
        fetch_valid = 2'b00; fetch_pred = 2'b00;
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    task automatic send(input logic [1:0] v, input logic [1:0] p);
        imem_resp   = 1'b1;
        fetch_valid = v;
        fetch_pred  = p;
        fetch_pc    = pc_next;
        imem_rdata  = {$urandom, $urandom};
        pc_next     = pc_next + 32'd8;
        step();
        imem_resp   = 1'b0;
    endtask

    initial begin
        idle();
        imem_rdata = '0;
        fetch_pc   = '0;
        pc_next    = 32'h1000_0000;

        // Reset values
        do_reset();
        chk("rst_dec_valid", dec_valid, 1'b0);
        chk("rst_queue_full", queue_full, 1'b0);
        chk("rst_overflow", overflow_err, 1'b0);

        // Basic enqueue
        dec_ready = 1'b1;
        imem_resp = 1'b1; fetch_valid = 2'b11; fetch_pred = 2'b00;
        fetch_pc = 32'h6000_0000; imem_rdata = {32'hBBBB_BBBB, 32'hAAAA_AAAA};
        step();
        imem_resp = 1'b0;
        chk("basic_inst0", dec_inst, 32'hAAAA_AAAA);
        chk("basic_pc0", dec_pc, 32'h6000_0000);
        step();
        chk("basic_inst1", dec_inst, 32'hBBBB_BBBB);
        chk("basic_pc1", dec_pc, 32'h6000_0004);
        step();
        chk("basic_empty", dec_valid, 1'b0);

        // Misaligned entry: only slot 1 valid
        dec_ready = 1'b0;
        imem_resp = 1'b1; fetch_valid = 2'b10; fetch_pred = 2'b10;
        fetch_pc = 32'h6000_0008; imem_rdata = {32'h1234_5678, 32'hDEAD_BEEF};
        step();
        imem_resp = 1'b0;
        chk("mis_pc", dec_pc, 32'h6000_000C);
        chk("mis_pred", dec_pred, 1'b1);
        chk("mis_inst", dec_inst, 32'h1234_5678);
        dec_ready = 1'b1;
        step();
        chk("mis_single", dec_valid, 1'b0);

        // Fill and wrap
        do_reset();
        for (int i = 0; i < 7; i++) send(2'b11, 2'($urandom));
        chk("fill_14_not_full", queue_full, 1'b0);
        send(2'b11, 2'b01);
        chk("fill_16_full", queue_full, 1'b1);
        for (int i = 0; i < 48; i++) begin
            dec_ready = 1'b1;
            if (!m_full()) send(2'b11, 2'($urandom));
            else step();
        end
        for (int i = 0; i < DEPTH + 2; i++) step();
        chk("wrap_drained", dec_valid, 1'b0);

        // Overflow at count 15
        do_reset();
        for (int i = 0; i < 7; i++) send(2'b11, 2'b00);
        send(2'b01, 2'b00);
        chk("ovf_full_at_15", queue_full, 1'b1);
        send(2'b01, 2'b00);
        chk("ovf_set", overflow_err, 1'b1);
        dec_ready = 1'b1;
        for (int i = 0; i < 15; i++) step();
        chk("ovf_15_drained", dec_valid, 1'b0);
        chk("ovf_sticky", overflow_err, 1'b1);

        // Flush with in-flight response
        do_reset();
        for (int i = 0; i < 3; i++) send(2'b11, 2'b00);
        branch_mispredict = 1'b1; imem_stall = 1'b1; dec_ready = 1'b1;
        step();
        branch_mispredict = 1'b0; imem_stall = 1'b0; dec_ready = 1'b0;
        chk("flush_empty", dec_valid, 1'b0);
        send(2'b11, 2'b00);
        chk("flush_stale_dropped", dec_valid, 1'b0);
        send(2'b11, 2'b00);
        chk("flush_next_enq", dec_valid, 1'b1);

        // Simultaneous enqueue/dequeue, then reset alongside a response
        do_reset();
        send(2'b11, 2'b00);
        send(2'b01, 2'b00);
        dec_ready = 1'b1;
        send(2'b11, 2'b11);
        chk("simul_count4", 64'(mq.size()), 64'd4);
        dec_ready = 1'b0;
        rst = 1'b1; imem_resp = 1'b1; fetch_valid = 2'b11;
        step();
        rst = 1'b0; imem_resp = 1'b0;
        chk("rst_mid_valid", dec_valid, 1'b0);
        chk("rst_mid_full", queue_full, 1'b0);
        chk("rst_mid_ovf", overflow_err, 1'b0);

        // Randomized traffic
        for (int blk = 0; blk < 6; blk++) begin
            for (int i = 0; i < 120; i++) begin
                rst               = ($urandom_range(0, 199) == 0);
                branch_mispredict = ($urandom_range(0, 24) == 0);
                imem_stall        = 1'($urandom);
                dec_ready         = ($urandom_range(0, 99) < blk * 20);
                imem_resp         = (!m_full() && $urandom_range(0, 2) != 0) ||
                                    ($urandom_range(0, 15) == 0);
                fetch_valid       = 2'($urandom);
                fetch_pred        = 2'($urandom);
                fetch_pc          = $urandom & 32'hFFFF_FFF8;
                imem_rdata        = {$urandom, $urandom};
                step();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
